// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache controller with one word per line.
// Sits between a single CPU requester and a single-port RAM that captures on the falling clock edge.
module dm_cache_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              cpu_busy,
    input  logic              cache_flush,
    output logic              mem_w_en,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MEM_RD,
        WR,
        FLUSH
    } state_t;

    state_t state_q, state_d;

    // Request captured at accept time; stays stable for the whole access.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_hit_q, cpu_hit_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              flush_pend_q, flush_pend_d;

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    logic              line_wr;
    logic [DATA_W-1:0] line_wdata;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               lookup_hit;

    assign idx        = addr_q[INDEX_W-1:0];
    assign req_tag    = addr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_ready_d  = 1'b0;
        cpu_hit_d    = 1'b0;
        mem_w_en_d   = 1'b0;
        mem_r_en_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        valid_d      = valid_q;
        line_wr      = 1'b0;
        line_wdata   = wdata_q;
        // A flush arriving mid-access is remembered and serviced on return to IDLE.
        flush_pend_d = flush_pend_q | (cache_flush && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (cache_flush || flush_pend_q) begin
                    state_d = FLUSH;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (we_q) begin
                    mem_w_en_d   = 1'b1;
                    mem_addr_d   = addr_q;
                    mem_wdata_d  = wdata_q;
                    line_wr      = 1'b1;
                    line_wdata   = wdata_q;
                    valid_d[idx] = 1'b1;
                    state_d      = WR;
                end else if (lookup_hit) begin
                    cpu_rdata_d = data_q[idx];
                    cpu_ready_d = 1'b1;
                    cpu_hit_d   = 1'b1;
                    if (hit_cnt_q != {CNT_W{1'b1}}) begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    mem_r_en_d = 1'b1;
                    mem_addr_d = addr_q;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                line_wr      = 1'b1;
                line_wdata   = mem_rdata;
                valid_d[idx] = 1'b1;
                cpu_rdata_d  = mem_rdata;
                cpu_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            WR: begin
                cpu_ready_d = 1'b1;
                state_d     = IDLE;
            end
            FLUSH: begin
                valid_d      = '0;
                flush_pend_d = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            mem_w_en_q   <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_hit_q    <= cpu_hit_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
        end
    end

    // Tag/data storage is not reset; validity alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (line_wr && !rst) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= line_wdata;
        end
    end

    assign cpu_busy  = (state_q != IDLE);
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_hit   = cpu_hit_q;
    assign mem_w_en  = mem_w_en_q;
    assign mem_r_en  = mem_r_en_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, write-allocate cache controller between a single CPU requester and the 1024x32 single-port backing RAM.
- One word per line; tag, valid and data arrays are internal flops.
- On miss/write, sequences the RAM's w_en/r_en/addr/data_in; the RAM captures on the falling clock edge, giving a 1-cycle read turnaround.
- Carries read hit/miss statistics counters.

Parameters:
ADDR_W, 10, word address width (matches RAM depth 1024)
DATA_W, 32, data word width
INDEX_W, 4, line index width; 2^INDEX_W lines; TAG_W = ADDR_W-INDEX_W
CNT_W, 16, width of hit/miss counters

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  request strobe, sampled only in IDLE
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address; index = [INDEX_W-1:0], tag = upper bits
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  qualifies cpu_ready: 1 = read hit
cpu_busy  out  1  combinational, state != IDLE
cache_flush  in  1  invalidate all lines
mem_w_en  out  1  to RAM w_en
mem_r_en  out  1  to RAM r_en
mem_addr  out  ADDR_W  to RAM addr
mem_wdata  out  DATA_W  to RAM data_in
mem_rdata  in  DATA_W  from RAM data_o
hit_cnt  out  CNT_W  read-hit count, saturating
miss_cnt  out  CNT_W  read-miss count, saturating

Behaviour:
- Reset: state=IDLE; all valid bits=0, tag/data arrays unchanged; cpu_rdata, cpu_ready, cpu_hit, mem_w_en, mem_r_en, mem_addr, mem_wdata, hit_cnt, miss_cnt, flush_pend=0. Reset mid-operation aborts it: no cpu_ready, mem enables low after the reset edge, partially filled line left invalid.
- All outputs registered except cpu_busy.
- States: IDLE, COMPARE, MEM_RD, WR, FLUSH.
- IDLE: if cache_flush or flush_pend -> FLUSH; cpu_req in the same cycle is dropped. Else if cpu_req: latch addr/we/wdata -> COMPARE (edge E0). cpu_req while busy is ignored; no queueing.
- COMPARE (edge E1):
  - Read hit (valid[idx] && tag[idx]==tag): cpu_rdata=data[idx], cpu_ready=1, cpu_hit=1, hit_cnt++ -> IDLE.
  - Read miss: mem_r_en=1, mem_addr=addr, miss_cnt++ -> MEM_RD.
  - Write: mem_w_en=1, mem_addr=addr, mem_wdata=wdata; data[idx]=wdata, tag[idx]=tag, valid[idx]=1 -> WR.
- MEM_RD (E2): mem_r_en=0; fill data[idx]=mem_rdata, tag, valid=1; cpu_rdata=mem_rdata, cpu_ready=1, cpu_hit=0 -> IDLE.
- WR (E2): mem_w_en=0; cpu_ready=1, cpu_hit=0 -> IDLE.
- Latency from accept edge E0: read hit, ready high E1..E2, next request accepted at E2; miss/write, ready high E2..E3, next accept at E3.
- cpu_ready and cpu_hit are exactly 1 cycle. cpu_rdata holds its value until the next read completes.
- mem_r_en and mem_w_en are never high together; each is high for exactly 1 cycle per access.
- FLUSH: all valid=0 in one edge, flush_pend=0 -> IDLE.
- cache_flush while busy sets flush_pend, which is serviced on the next IDLE before any request.
- Counters saturate at 2^CNT_W-1. Writes are not counted.
- Write to a line currently holding a different tag overwrites it; write-through, so no eviction traffic.

Test Plan:
- Reset, then read addr 0x005 with RAM[0x005]=0xDEADBEEF -> mem_r_en one cycle at addr 0x005, cpu_ready at E2, cpu_rdata=0xDEADBEEF, cpu_hit=0, miss_cnt=1.
- Repeat read 0x005 -> no mem_r_en, cpu_ready at E1, cpu_hit=1, rdata=0xDEADBEEF, hit_cnt=1.
- Write 0x015 (same index 5, new tag) data 0x12345678 -> mem_w_en one cycle, RAM[0x015]=0x12345678. Read 0x015 -> hit, 0x12345678. Read 0x005 -> miss, refetch 0xDEADBEEF.
- cache_flush pulsed during a miss at E1 -> miss completes normally, then FLUSH occurs. Next read of 0x005 -> miss.
- rst asserted in MEM_RD -> no cpu_ready, mem_r_en=0, counters 0. Read 0x005 afterwards -> miss.
- Force hit_cnt to 0xFFFE, issue 3 read hits -> hit_cnt saturates at 0xFFFF. cpu_req held high while busy -> only one access per accept.
